// File: rtl/pc_seq_pkg.sv
// Shared encodings for the program-counter sequencer: request opcodes and FSM states.
package pc_seq_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_STEP = 2'b00;
    localparam op_t OP_JUMP = 2'b01;
    localparam op_t OP_CALL = 2'b10;
    localparam op_t OP_RET  = 2'b11;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;

endpackage

// File: rtl/pc_sequencer_if.sv
// Request handshake between the instruction decoder (master) and pc_sequencer (slave).
interface pc_sequencer_if #(
    parameter int WIDTH = 8
) ();

    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_addr;

    modport master (
        output req_valid,
        output req_op,
        output req_addr,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_op,
        input  req_addr,
        output req_ready
    );

endinterface

// File: rtl/pc_return_stack.sv
// LIFO return-address stack: registered storage, count pointer, combinational top-of-stack.
module pc_return_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      cnt;
    logic [AW-1:0]    top_idx;

    // Top entry sits one below the count; value at count==0 is don't-care.
    assign top_idx = cnt[AW-1:0] - AW'(1);
    assign rdata   = mem[top_idx];
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !full) begin
            mem[cnt[AW-1:0]] <= wdata;
            cnt              <= cnt + (AW+1)'(1);
        end else if (pop && !empty) begin
            cnt <= cnt - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC flow sequencer: turns STEP/JUMP/CALL/RET requests into one-cycle counter strobes.
// Optional sticky stack-error flag enabled by defining PC_SEQ_STICKY_ERR_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    pc_sequencer_if.slave          req,
    input  logic                   halt,
    input  logic [WIDTH-1:0]       pc_in,
    output logic                   pc_inc,
    output logic                   pc_load,
    output logic [WIDTH-1:0]       pc_preset,
    output logic                   done,
    output logic                   stack_err,
    output logic [$clog2(DEPTH):0] depth
`ifdef PC_SEQ_STICKY_ERR_EN
    ,
    output logic                   err_sticky
`endif
);

    logic [1:0]       state;
    op_t              op_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] ret_q;
    logic [WIDTH-1:0] preset_q;
    logic [WIDTH-1:0] preset_val;
    logic             handshake;
    logic             issue;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] top;

    assign req.req_ready = (state == S_IDLE) && !halt;
    assign handshake     = req.req_valid && req.req_ready;
    assign issue         = (state == S_ISSUE);
    assign push          = issue && (op_q == OP_CALL) && !full;
    assign pop           = issue && (op_q == OP_RET) && !empty;
    assign done          = (state == S_SETTLE);

    pc_return_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wdata   (ret_q),
        .rdata   (top),
        .full    (full),
        .empty   (empty),
        .count   (depth)
    );

    // Strobes decode straight from state so an async reset removes them at once.
    always_comb begin
        pc_inc     = issue && (op_q == OP_STEP);
        pc_load    = (issue && (op_q == OP_JUMP)) || push || pop;
        stack_err  = issue && (((op_q == OP_CALL) && full) || ((op_q == OP_RET) && empty));
        preset_val = (op_q == OP_RET) ? top : addr_q;
        pc_preset  = pc_load ? preset_val : preset_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            op_q     <= OP_STEP;
            addr_q   <= '0;
            ret_q    <= '0;
            preset_q <= '0;
        end else begin
            if (pc_load) begin
                preset_q <= preset_val;
            end
            case (state)
                S_IDLE: begin
                    if (handshake) begin
                        state  <= S_ISSUE;
                        op_q   <= req.req_op;
                        addr_q <= req.req_addr;
                        ret_q  <= pc_in + WIDTH'(1);
                    end
                end
                S_ISSUE:  state <= S_SETTLE;
                S_SETTLE: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

`ifdef PC_SEQ_STICKY_ERR_EN
    // Errors are only raised in ISSUE and clears only at an IDLE handshake, so they never collide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_sticky <= 1'b0;
        end else if (stack_err) begin
            err_sticky <= 1'b1;
        end else if (handshake && (req.req_op == OP_RET) && (depth != '0) && err_sticky) begin
            err_sticky <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (DEPTH=4); sticky flag checked when PC_SEQ_STICKY_ERR_EN is defined.
module tb_pc_sequencer;

    localparam logic [1:0] STEP = 2'b00;
    localparam logic [1:0] JUMP = 2'b01;
    localparam logic [1:0] CALL = 2'b10;
    localparam logic [1:0] RET  = 2'b11;

    logic       clk;
    logic       reset_n;
    logic       halt;
    logic [7:0] pc_in;
    logic       pc_inc;
    logic       pc_load;
    logic [7:0] pc_preset;
    logic       done;
    logic       stack_err;
    logic [2:0] depth;
`ifdef PC_SEQ_STICKY_ERR_EN
    logic       err_sticky;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] hold = 8'h00;

    pc_sequencer_if #(.WIDTH(8)) req_if ();

    pc_sequencer #(
        .WIDTH (8),
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req_if),
        .halt      (halt),
        .pc_in     (pc_in),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .pc_preset (pc_preset),
        .done      (done),
        .stack_err (stack_err),
        .depth     (depth)
`ifdef PC_SEQ_STICKY_ERR_EN
        ,
        .err_sticky (err_sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge in IDLE; ends at the negedge where IDLE is back (handshake+3).
    task automatic run_req(input string tag, input logic [1:0] op, input logic [7:0] addr,
                           input logic [7:0] pc, input logic e_inc, input logic e_load,
                           input logic [7:0] e_preset, input logic e_err, input logic [2:0] e_depth);
        req_if.req_valid = 1'b1;
        req_if.req_op    = op;
        req_if.req_addr  = addr;
        pc_in            = pc;
        #1;
        chk({tag, " ready_idle"}, req_if.req_ready, 1);
        @(negedge clk);
        req_if.req_valid = 1'b0;
        req_if.req_addr  = 8'hAA;
        pc_in            = 8'h55;
        #1;
        if (e_load) hold = e_preset;
        chk({tag, " inc"}, pc_inc, e_inc);
        chk({tag, " load"}, pc_load, e_load);
        chk({tag, " preset"}, pc_preset, hold);
        chk({tag, " err"}, stack_err, e_err);
        chk({tag, " ready_issue"}, req_if.req_ready, 0);
        chk({tag, " done_issue"}, done, 0);
        @(negedge clk);
        chk({tag, " done"}, done, 1);
        chk({tag, " strobes_settle"}, {pc_inc, pc_load, stack_err}, 3'b000);
        chk({tag, " ready_settle"}, req_if.req_ready, 0);
        chk({tag, " depth"}, depth, e_depth);
        chk({tag, " preset_hold"}, pc_preset, hold);
        @(negedge clk);
        chk({tag, " ready_back"}, req_if.req_ready, 1);
        chk({tag, " done_off"}, done, 0);
    endtask

    initial begin
        reset_n          = 1'b0;
        halt             = 1'b0;
        pc_in            = 8'h00;
        req_if.req_valid = 1'b0;
        req_if.req_op    = STEP;
        req_if.req_addr  = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset ready", req_if.req_ready, 1);
        chk("reset depth", depth, 0);
        chk("reset strobes", {pc_inc, pc_load, done, stack_err}, 4'b0000);
        chk("reset preset", pc_preset, 8'h00);
        reset_n = 1'b1;
        @(negedge clk);

        run_req("step10", STEP, 8'h00, 8'h10, 1, 0, 8'h00, 0, 3'd0);

        // Reset while a JUMP to 0x40 is in ISSUE.
        req_if.req_valid = 1'b1;
        req_if.req_op    = JUMP;
        req_if.req_addr  = 8'h40;
        @(negedge clk);
        req_if.req_valid = 1'b0;
        #1;
        chk("rstmid load", pc_load, 1);
        chk("rstmid preset", pc_preset, 8'h40);
        reset_n = 1'b0;
        #1;
        chk("rstmid load_drop", pc_load, 0);
        chk("rstmid ready", req_if.req_ready, 1);
        chk("rstmid depth", depth, 0);
        @(negedge clk);
        chk("rstmid no_done", done, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rstmid no_done2", done, 0);
        hold = 8'h00;

        run_req("call80", CALL, 8'h80, 8'h22, 0, 1, 8'h80, 0, 3'd1);
        run_req("ret23", RET, 8'h00, 8'h81, 0, 1, 8'h23, 0, 3'd0);

        run_req("call1", CALL, 8'hA0, 8'h00, 0, 1, 8'hA0, 0, 3'd1);
        run_req("call2", CALL, 8'hA1, 8'h10, 0, 1, 8'hA1, 0, 3'd2);
        run_req("call3", CALL, 8'hA2, 8'h20, 0, 1, 8'hA2, 0, 3'd3);
        run_req("call4", CALL, 8'hA3, 8'h30, 0, 1, 8'hA3, 0, 3'd4);
        run_req("call5_full", CALL, 8'hA4, 8'h40, 0, 0, 8'h00, 1, 3'd4);
        run_req("ret1", RET, 8'h00, 8'h00, 0, 1, 8'h31, 0, 3'd3);
        run_req("ret2", RET, 8'h00, 8'h00, 0, 1, 8'h21, 0, 3'd2);
        run_req("ret3", RET, 8'h00, 8'h00, 0, 1, 8'h11, 0, 3'd1);
        run_req("ret4", RET, 8'h00, 8'h00, 0, 1, 8'h01, 0, 3'd0);
        run_req("ret5_empty", RET, 8'h00, 8'h00, 0, 0, 8'h00, 1, 3'd0);
`ifdef PC_SEQ_STICKY_ERR_EN
        chk("sticky set", err_sticky, 1);
`endif

        halt             = 1'b1;
        req_if.req_valid = 1'b1;
        req_if.req_op    = STEP;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("halt ready", req_if.req_ready, 0);
            chk("halt strobes", {pc_inc, pc_load, done}, 3'b000);
            @(negedge clk);
        end
        halt = 1'b0;
        run_req("step_ff", STEP, 8'h00, 8'hFF, 1, 0, 8'h00, 0, 3'd0);

        run_req("call_ff", CALL, 8'h05, 8'hFF, 0, 1, 8'h05, 0, 3'd1);
`ifdef PC_SEQ_STICKY_ERR_EN
        chk("sticky kept", err_sticky, 1);
`endif
        run_req("ret_wrap", RET, 8'h00, 8'h06, 0, 1, 8'h00, 0, 3'd0);
`ifdef PC_SEQ_STICKY_ERR_EN
        chk("sticky clear", err_sticky, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Controller that sequences the 8-bit program counter: it turns one-at-a-time flow requests into single-cycle counter control strobes.
- Request types: step, jump, call, return.
- Holds a small return-address stack for call/return.
- Sits between the instruction decoder (requester) and the loadable up-counter used as the PC.

Parameters:
- WIDTH, 8, PC/address width
- DEPTH, 4, return-stack entries (power of two, 2..16)

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  sequencer can accept a request this cycle
- req_op  input  2  request type: 00 STEP, 01 JUMP, 10 CALL, 11 RET
- req_addr  input  WIDTH  target address for JUMP/CALL
- halt  input  1  freeze: blocks acceptance of new requests
- pc_in  input  WIDTH  current counter value
- pc_inc  output  1  one-cycle increment strobe to the counter
- pc_load  output  1  one-cycle load strobe to the counter
- pc_preset  output  WIDTH  load value, valid while pc_load is high
- done  output  1  one-cycle pulse when a request completes
- stack_err  output  1  one-cycle pulse on CALL-when-full or RET-when-empty
- depth  output  $clog2(DEPTH)+1  current stack occupancy

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous and active-low.
- Reset (reset_n low, asynchronous): state IDLE, stack empty, depth=0. All outputs low or zero, except req_ready, which follows the IDLE rule below.
- FSM states: IDLE, ISSUE, SETTLE.
- IDLE:
  - req_ready = !halt.
  - Handshake when req_valid && req_ready: latch op, addr and pc_in, go to ISSUE.
  - req_ready is low in ISSUE and SETTLE.
- ISSUE (exactly one cycle), by op:
  - STEP: pc_inc=1.
  - JUMP: pc_load=1, pc_preset=addr.
  - CALL, stack not full: push latched pc_in+1 (mod 2^WIDTH); pc_load=1, pc_preset=addr.
  - CALL, stack full: no push, no strobe, stack_err=1.
  - RET, stack not empty: pop; pc_load=1, pc_preset=popped value.
  - RET, stack empty: no strobe, stack_err=1.
  - Next state SETTLE.
- SETTLE (one cycle): done=1; counter output is settled. Next state IDLE.
- Timing:
  - Handshake at edge N; strobe in cycle N+1; done in cycle N+2.
  - Next handshake at the earliest in cycle N+3, i.e. throughput one request per 3 cycles.
- pc_inc and pc_load are never high together. pc_preset holds its last value when pc_load is low.
- halt:
  - Only gates acceptance in IDLE.
  - A request already accepted completes normally.
  - halt and req_valid in the same IDLE cycle: halt wins, no handshake.
- Wrap-around:
  - CALL at pc_in=0xFF pushes 0x00.
  - STEP at 0xFF is issued normally; the counter wraps.
- Stack is LIFO. Push and pop never occur in the same cycle. depth updates on the ISSUE edge.
- reset_n asserted mid-request: request abandoned; strobes drop immediately; no done pulse.
- req_addr and pc_in are sampled only at the handshake. Later changes are ignored.

Optional Feature:
- Macro: PC_SEQ_STICKY_ERR_EN.
- Defined:
  - Adds output err_sticky (1 bit), set on any stack_err pulse.
  - Cleared only by reset_n, or by a RET accepted while depth>0 and err_sticky=1; the RET also executes normally.
- Undefined: port absent; stack_err pulse only.

Decomposition:
- Shared package pc_seq_pkg:
  - op encodings OP_STEP/OP_JUMP/OP_CALL/OP_RET (2 bits)
  - FSM state encodings S_IDLE/S_ISSUE/S_SETTLE
- Sub-module pc_return_stack (parameters WIDTH, DEPTH):
  - ports: push, pop, wdata, rdata, full, empty, count
  - clk/reset_n as above
  - registered storage with pointer; top-of-stack rdata combinational

Test Plan:
- Reset: hold reset_n low mid-ISSUE of a JUMP to 0x40 -> pc_load drops immediately; req_ready=1, depth=0, done never pulses.
- STEP at pc_in=0x10: handshake at cycle 0 -> pc_inc=1 in cycle 1 only, done in cycle 2, req_ready low cycles 1-2, high cycle 3.
- CALL 0x80 at pc_in=0x22, then RET -> first pc_preset=0x80, depth=1; RET pc_preset=0x23, depth=0.
- Five CALLs with DEPTH=4, from pc_in 0x00,0x10,0x20,0x30,0x40 -> fifth: stack_err=1, no pc_load, depth stays 4. Four RETs yield 0x31,0x21,0x11,0x01; a fifth RET gives stack_err=1.
- halt=1 with req_valid=1 in IDLE for 5 cycles -> req_ready=0, no strobes. Drop halt -> handshake next cycle.
- CALL at pc_in=0xFF to 0x05, then RET -> pc_preset=0x00. With PC_SEQ_STICKY_ERR_EN: an underflow sets err_sticky, which stays set until a subsequent valid RET clears it.
